line_buffer_ctrl: RTL and testbench

//  Drives a bank of NUM_LB=4 data_buffer line buffers. It takes an 8-bit pixel stream,

---
 rtl/line_buffer_ctrl.sv | 137 +++++++++++++
 tb/tb_line_buffer_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// Line buffer controller: round-robin line writes into four buffers and
// parallel three-line reads that form a registered 3x3 window stream.
module line_buffer_ctrl #(
    parameter int IMAGE_WIDTH = 512,
    parameter int IW_BIT_NUM  = 9,
    parameter int FILL_BITS   = IW_BIT_NUM + 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_pixel,
    input  logic        in_pixel_valid,
    output logic [7:0]  lb_wr_pixel,
    output logic [3:0]  lb_wr_valid,
    input  logic [95:0] lb_rd_data,
    output logic [3:0]  lb_rd_en,
    output logic [71:0] out_window,
    output logic        out_window_valid,
    output logic        line_done_intr
);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    localparam logic [IW_BIT_NUM-1:0] CNT_LAST = IW_BIT_NUM'(IMAGE_WIDTH - 1);
    localparam logic [FILL_BITS-1:0]  FILL_THR = FILL_BITS'(3 * IMAGE_WIDTH);

    state_t                state_q, state_d;
    logic [IW_BIT_NUM-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]            wr_sel_q, wr_sel_d;
    logic [IW_BIT_NUM-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]            rd_sel_q, rd_sel_d;
    logic [FILL_BITS-1:0]  fill_q, fill_d;
    logic [71:0]           win_q, win_d;
    logic                  win_valid_q, win_valid_d;
    logic                  intr_q, intr_d;

    logic [23:0] buf_data [4];
    logic [1:0]  sel1, sel2;
    logic        rd_active;

    assign sel1      = rd_sel_q + 2'd1;
    assign sel2      = rd_sel_q + 2'd2;
    assign rd_active = (state_q == READ);

    assign lb_wr_pixel      = in_pixel;
    assign lb_wr_valid      = in_pixel_valid ? (4'b0001 << wr_sel_q) : 4'b0000;
    assign out_window       = win_q;
    assign out_window_valid = win_valid_q;
    assign line_done_intr   = intr_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            buf_data[i] = lb_rd_data[24*i +: 24];
        end
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        wr_sel_d = wr_sel_q;
        if (in_pixel_valid) begin
            if (wr_cnt_q == CNT_LAST) begin
                wr_cnt_d = '0;
                wr_sel_d = wr_sel_q + 2'd1;
            end else begin
                wr_cnt_d = wr_cnt_q + IW_BIT_NUM'(1);
            end
        end
    end

    // Simultaneous write and read cancel out, so fill only moves on one-sided cycles.
    always_comb begin
        fill_d = fill_q;
        unique case ({in_pixel_valid, rd_active})
            2'b10:   fill_d = fill_q + FILL_BITS'(1);
            2'b01:   fill_d = fill_q - FILL_BITS'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_sel_d    = rd_sel_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        intr_d      = 1'b0;
        lb_rd_en    = 4'b0000;
        unique case (state_q)
            IDLE: begin
                if (fill_q >= FILL_THR) begin
                    state_d = READ;
                end
            end
            READ: begin
                lb_rd_en    = (4'b0001 << rd_sel_q) | (4'b0001 << sel1)
                            | (4'b0001 << sel2);
                win_d       = {buf_data[rd_sel_q], buf_data[sel1], buf_data[sel2]};
                win_valid_d = 1'b1;
                rd_cnt_d    = rd_cnt_q + IW_BIT_NUM'(1);
                if (rd_cnt_q == CNT_LAST) begin
                    rd_cnt_d = '0;
                    rd_sel_d = rd_sel_q + 2'd1;
                    intr_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            wr_sel_q    <= '0;
            rd_cnt_q    <= '0;
            rd_sel_q    <= '0;
            fill_q      <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            intr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_sel_q    <= wr_sel_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_sel_q    <= rd_sel_d;
            fill_q      <= fill_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            intr_q      <= intr_d;
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: behavioural line-buffer bank plus a window
// scoreboard filled from the pixels sent and drained by a monitor.
module tb_line_buffer_ctrl;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_pixel;
    logic        in_pixel_valid;
    logic [7:0]  lb_wr_pixel;
    logic [3:0]  lb_wr_valid;
    logic [95:0] lb_rd_data;
    logic [3:0]  lb_rd_en;
    logic [71:0] out_window;
    logic        out_window_valid;
    logic        line_done_intr;

    line_buffer_ctrl #(.IMAGE_WIDTH(W), .IW_BIT_NUM(3)) dut (
        .clk(clk),
        .reset(reset),
        .in_pixel(in_pixel),
        .in_pixel_valid(in_pixel_valid),
        .lb_wr_pixel(lb_wr_pixel),
        .lb_wr_valid(lb_wr_valid),
        .lb_rd_data(lb_rd_data),
        .lb_rd_en(lb_rd_en),
        .out_window(out_window),
        .out_window_valid(out_window_valid),
        .line_done_intr(line_done_intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] win;
        logic [3:0]  rden;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   nchk = 0;
    int   nerr = 0;

    logic [7:0]  mem [4][W];
    int          wptr [4];
    int          rptr [4];
    logic [63:0] lines [0:31];
    logic [63:0] cur_line;
    int          nlines, nreads, wpos;
    logic [7:0]  pix_val;
    logic [71:0] last_win;
    logic [3:0]  prev_rden;

    // Line buffer model: writes append, read enables advance a pointer,
    // and positions past the line end read back as zero.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                wptr[i] <= 0;
                rptr[i] <= 0;
            end else begin
                if (lb_wr_valid[i]) begin
                    mem[i][wptr[i]] <= lb_wr_pixel;
                    wptr[i] <= (wptr[i] + 1) % W;
                end
                if (lb_rd_en[i]) rptr[i] <= (rptr[i] + 1) % W;
            end
        end
    end

    always_comb begin
        lb_rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (rptr[i] + k < W)
                    lb_rd_data[24*i + 8*(2-k) +: 8] = mem[i][rptr[i] + k];
            end
        end
    end

    task automatic check(input string name, input logic [71:0] act,
                         input logic [71:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: got timeout/unexpected expected none", name);
    endtask

    function automatic logic [23:0] seg(input int l, input int p);
        logic [23:0] s;
        logic [63:0] ln;
        s  = '0;
        ln = lines[l];
        for (int k = 0; k < 3; k++) begin
            if (p + k < W) s[8*(2-k) +: 8] = ln[8*(p+k) +: 8];
        end
        return s;
    endfunction

    function automatic logic [3:0] rden_of(input int s);
        logic [3:0] m;
        m = '0;
        for (int k = 0; k < 3; k++) m[(s + k) % 4] = 1'b1;
        return m;
    endfunction

    task automatic push_read(input int r);
        exp_t e;
        for (int p = 0; p < W; p++) begin
            e.win  = {seg(r, p), seg(r + 1, p), seg(r + 2, p)};
            e.rden = rden_of(r % 4);
            e.last = (p == W - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic v);
        @(posedge clk);
        #1;
        in_pixel_valid = v;
        in_pixel       = pix_val;
        #1;
        if (v) begin
            check("wr_valid", 72'(lb_wr_valid), 72'(4'b0001 << (nlines % 4)));
            check("wr_pixel", 72'(lb_wr_pixel), 72'(pix_val));
            cur_line[8*wpos +: 8] = pix_val;
            pix_val = pix_val + 8'd1;
            wpos++;
            if (wpos == W) begin
                lines[nlines] = cur_line;
                nlines++;
                wpos = 0;
                while (nlines >= nreads + 3) begin
                    push_read(nreads);
                    nreads++;
                end
            end
        end else begin
            check("wr_idle", 72'(lb_wr_valid), 72'd0);
        end
    endtask

    task automatic stop_input();
        @(posedge clk);
        #1;
        in_pixel_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_window_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) fail("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        prev_rden = '0;
        last_win  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_rden = '0;
            end else begin
                if (out_window_valid) begin
                    if (exp_q.size() == 0) begin
                        fail("window_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("window", out_window, e.win);
                        check("rd_en", 72'(prev_rden), 72'(e.rden));
                        check("intr", 72'(line_done_intr), 72'(e.last));
                        last_win = e.win;
                    end
                end else if (line_done_intr) begin
                    fail("intr_stray");
                end
                prev_rden = lb_rd_en;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < W; j++) mem[i][j] = '0;
        reset          = 1'b1;
        in_pixel       = '0;
        in_pixel_valid = 1'b0;
        nlines         = 0;
        nreads         = 0;
        wpos           = 0;
        cur_line       = '0;
        pix_val        = 8'h01;

        repeat (2) @(posedge clk);
        #1;
        check("rst_window", out_window, 72'd0);
        check("rst_valid", 72'(out_window_valid), 72'd0);
        check("rst_intr", 72'(line_done_intr), 72'd0);
        check("rst_rd_en", 72'(lb_rd_en), 72'd0);
        check("rst_wr_valid", 72'(lb_wr_valid), 72'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) send(1'b1);
        for (int i = 0; i < 16; i++) send(1'b1);
        stop_input();
        check("rd_latency_idle", 72'(lb_rd_en), 72'd0);
        @(posedge clk);
        #1;
        check("rd_start", 72'(lb_rd_en), 72'(4'b0111));
        drain();

        for (int i = 0; i < 48; i++) send(1'b1);
        stop_input();
        drain();
        check("window_hold", out_window, last_win);
        check("valid_idle", 72'(out_window_valid), 72'd0);

        for (int i = 0; i < 8; i++) send(1'b1);
        stop_input();
        n = 0;
        while (lb_rd_en == 4'b0000 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) fail("read_start_timeout");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rd_en", 72'(lb_rd_en), 72'd0);
        check("abort_valid", 72'(out_window_valid), 72'd0);
        check("abort_intr", 72'(line_done_intr), 72'd0);
        exp_q.delete();
        nlines = 0;
        nreads = 0;
        wpos   = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 24; i++) send(1'b1);
        stop_input();
        drain();

        for (int i = 0; i < 48; i++) send((i % 2) == 0);
        stop_input();
        drain();
        check("final_valid", 72'(out_window_valid), 72'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
